mips150_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of the MIPS150 control decoder.
//  - Owns the PC and drives a synchronous instruction memory (1-cycle read latency).
//  - Registers the returned word onto Instr/PC_D for the decoder and datapath.
//  - Supports decode stall, execute-stage redirect (branch/jump target) and flush-to-bubble.

---
 rtl/mips150_fetch.sv | 163 ++++++++++++++++
 tb/tb_mips150_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips150_fetch.sv
// MIPS150 instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem, registers Instr/PC_D.
// Optional alignment checker enabled by defining MIPS150_FETCH_ALIGN_CHK_EN (adds fetch_misalign).
module mips150_fetch #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000,
   parameter int          IMEM_AW  = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_target,
   output logic               imem_en,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_dout,
   output logic [31:0]        Instr,
   output logic [31:0]        PC_D,
   output logic [31:0]        PC_plus4_D,
   output logic               instr_valid
`ifdef MIPS150_FETCH_ALIGN_CHK_EN
   ,
   output logic               fetch_misalign
`endif
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_t;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_v_q, pend_v_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic [31:0] pc_p0, pc_p0_d;
   logic [31:0] hold_word_p1, hold_word_d;
   logic        vld_hold_p1, vld_hold_d;
   logic [31:0] instr_d, pc_d_d, pc_plus4_d_d;
   logic        instr_valid_d;
   logic        fetch_en;
   logic [31:0] fetch_pc;
   logic [31:0] tgt;
   logic [31:0] cap_word;
   logic        cap_v;

   // A pending redirect replaces the sequential PC as soon as fetch resumes.
   assign fetch_pc  = pend_v_q ? pend_tgt_q : pc_q;
   assign tgt       = word_align(redirect_target);
   assign imem_en   = rst_n & fetch_en;
   assign imem_addr = rst_n ? fetch_pc[IMEM_AW+1:2] : RESET_PC[IMEM_AW+1:2];

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_v_d      = pend_v_q;
      pend_tgt_d    = pend_tgt_q;
      pc_p0_d       = pc_p0;
      hold_word_d   = hold_word_p1;
      vld_hold_d    = vld_hold_p1;
      instr_d       = Instr;
      pc_d_d        = PC_D;
      pc_plus4_d_d  = PC_plus4_D;
      instr_valid_d = instr_valid;
      fetch_en      = 1'b0;
      cap_word      = imem_dout;
      cap_v         = 1'b1;
      case (state_q)
         S_BOOT: begin
            fetch_en = 1'b1;
            pc_p0_d  = pc_q;
            pc_d     = pc_inc(pc_q);
            if (redirect_valid) begin
               pend_v_d   = 1'b1;
               pend_tgt_d = tgt;
            end
            state_d = S_RUN;
         end
         default: begin
            // In S_HOLD the word that arrived during the stall lives in the hold register.
            if (state_q == S_HOLD) begin
               cap_word = hold_word_p1;
               cap_v    = vld_hold_p1;
            end
            if (flush) begin
               instr_d       = 32'h0;
               instr_valid_d = 1'b0;
               pc_d_d        = pc_p0;
               pc_plus4_d_d  = pc_inc(pc_p0);
               vld_hold_d    = 1'b0;
            end else if (!stall && cap_v) begin
               instr_d       = cap_word;
               instr_valid_d = 1'b1;
               pc_d_d        = pc_p0;
               pc_plus4_d_d  = pc_inc(pc_p0);
            end
            if (!stall) begin
               fetch_en   = 1'b1;
               pc_p0_d    = fetch_pc;
               pc_d       = redirect_valid ? tgt : pc_inc(fetch_pc);
               pend_v_d   = 1'b0;
               vld_hold_d = 1'b0;
               state_d    = S_RUN;
            end else begin
               if (!flush) begin
                  hold_word_d = cap_word;
                  vld_hold_d  = cap_v;
               end
               if (redirect_valid) begin
                  pend_v_d   = 1'b1;
                  pend_tgt_d = tgt;
               end
               state_d = S_HOLD;
            end
         end
      endcase
   end

   // p0: fetch issued to imem / p1: word held during stall / decode outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_BOOT;
         pc_q         <= RESET_PC;
         pend_v_q     <= 1'b0;
         pend_tgt_q   <= 32'h0;
         pc_p0        <= RESET_PC;
         hold_word_p1 <= 32'h0;
         vld_hold_p1  <= 1'b0;
         Instr        <= 32'h0;
         PC_D         <= RESET_PC;
         PC_plus4_D   <= pc_inc(RESET_PC);
         instr_valid  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_v_q     <= pend_v_d;
         pend_tgt_q   <= pend_tgt_d;
         pc_p0        <= pc_p0_d;
         hold_word_p1 <= hold_word_d;
         vld_hold_p1  <= vld_hold_d;
         Instr        <= instr_d;
         PC_D         <= pc_d_d;
         PC_plus4_D   <= pc_plus4_d_d;
         instr_valid  <= instr_valid_d;
      end
   end

`ifdef MIPS150_FETCH_ALIGN_CHK_EN
   // Sticky: once a misaligned target is seen, only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_misalign <= 1'b0;
      end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
         fetch_misalign <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mips150_fetch.sv
// Self-checking bench for mips150_fetch: directed scenarios plus randomized traffic against a queue-based model.
// Build with MIPS150_FETCH_ALIGN_CHK_EN defined to also exercise fetch_misalign.
module tb_mips150_fetch;
   localparam logic [31:0] RPC = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        imem_en;
   logic [11:0] imem_addr;
   logic [31:0] imem_dout = 32'h0;
   logic [31:0] Instr, PC_D, PC_plus4_D;
   logic        instr_valid;
`ifdef MIPS150_FETCH_ALIGN_CHK_EN
   logic        fetch_misalign;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: program-order view with a queue of fetched-but-undelivered PCs.
   logic        m_booted, m_pend_v, m_mis;
   logic [31:0] m_pc, m_pend_t;
   logic [31:0] q[$];
   logic [31:0] e_instr, e_pcd;
   logic        e_iv, e_en, o_en;
   logic [11:0] e_addr, o_addr;

   mips150_fetch dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
      .Instr(Instr), .PC_D(PC_D), .PC_plus4_D(PC_plus4_D), .instr_valid(instr_valid)
`ifdef MIPS150_FETCH_ALIGN_CHK_EN
      , .fetch_misalign(fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [11:0] wa);
      return {wa, 8'hC3, wa};
   endfunction

   always @(posedge clk) if (imem_en) imem_dout <= mem_word(imem_addr);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_booted = 1'b0; m_pend_v = 1'b0; m_mis = 1'b0;
      m_pc = RPC; m_pend_t = 32'h0; q.delete();
      e_instr = 32'h0; e_pcd = RPC; e_iv = 1'b0;
   endtask

   task automatic hold_reset();
      stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
   endtask

   // One clock cycle: drive inputs, sample imem request at negedge, advance the model, land at posedge+1.
   task automatic step(input logic s, input logic f, input logic rv, input logic [31:0] t);
      logic [31:0] tg, fp;
      stall = s; flush = f; redirect_valid = rv; redirect_target = t;
      @(negedge clk);
      o_en = imem_en; o_addr = imem_addr;
      tg = t & 32'hFFFF_FFFC;
      if (rv && t[1:0] != 2'b00) m_mis = 1'b1;
      if (!m_booted) begin
         e_en = 1'b1; e_addr = m_pc[13:2];
         q.push_back(m_pc);
         m_pc = m_pc + 32'd4;
         if (rv) begin m_pend_v = 1'b1; m_pend_t = tg; end
         m_booted = 1'b1;
      end else begin
         fp = m_pend_v ? m_pend_t : m_pc;
         e_en = !s; e_addr = fp[13:2];
         if (f) begin
            if (q.size() > 0) e_pcd = q.pop_front();
            e_instr = 32'h0; e_iv = 1'b0;
         end else if (!s && q.size() > 0) begin
            e_pcd = q.pop_front();
            e_instr = mem_word(e_pcd[13:2]); e_iv = 1'b1;
         end
         if (!s) begin
            q.push_back(fp);
            m_pc = rv ? tg : fp + 32'd4;
            m_pend_v = 1'b0;
         end else if (rv) begin
            m_pend_v = 1'b1; m_pend_t = tg;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      hold_reset();
      checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want %h", Instr, 32'h0); end
      checks++; if (PC_D !== RPC) begin errors++; $display("FAIL rst_pcd: got %h want %h", PC_D, RPC); end
      checks++; if (PC_plus4_D !== RPC + 32'd4) begin errors++; $display("FAIL rst_pcp4: got %h want %h", PC_plus4_D, RPC + 32'd4); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL rst_imem_en: got %b want 0", imem_en); end
      checks++; if (imem_addr !== RPC[13:2]) begin errors++; $display("FAIL rst_imem_addr: got %h want %h", imem_addr, RPC[13:2]); end
`ifdef MIPS150_FETCH_ALIGN_CHK_EN
      checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", fetch_misalign); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      hold_reset(); rst_n = 1'b1;
      step(0, 0, 0, 0);
      checks++; if (o_en !== 1'b1 || o_addr !== 12'h000) begin errors++; $display("FAIL seq_fetch0: got en=%b addr=%h want en=1 addr=000", o_en, o_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_early: got %b want 0", instr_valid); end
      step(0, 0, 0, 0);
      checks++; if (o_addr !== 12'h001) begin errors++; $display("FAIL seq_fetch1: got %h want 001", o_addr); end
      checks++; if (instr_valid !== 1'b1 || Instr !== mem_word(12'h000) || PC_D !== RPC) begin
         errors++; $display("FAIL seq_first_word: got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", instr_valid, Instr, PC_D, mem_word(12'h000), RPC); end
      step(0, 0, 0, 0);
      checks++; if (o_addr !== 12'h002 || PC_D !== RPC + 32'd4 || PC_plus4_D !== RPC + 32'd8) begin
         errors++; $display("FAIL seq_fetch2: got addr=%h pc=%h pc4=%h", o_addr, PC_D, PC_plus4_D); end
   endtask

   task automatic test_stall();
      logic [31:0] si, sp;
      hold_reset(); rst_n = 1'b1;
      repeat (4) step(0, 0, 0, 0);
      si = Instr; sp = PC_D;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         checks++; if (o_en !== 1'b0 || Instr !== si || PC_D !== sp) begin
            errors++; $display("FAIL stall_hold%0d: got en=%b instr=%h pc=%h want en=0 instr=%h pc=%h", i, o_en, Instr, PC_D, si, sp); end
      end
      step(0, 0, 0, 0);
      checks++; if (PC_D !== sp + 32'd4 || instr_valid !== 1'b1 || o_addr !== 12'h004) begin
         errors++; $display("FAIL stall_resume: got pc=%h v=%b addr=%h want pc=%h v=1 addr=004", PC_D, instr_valid, o_addr, sp + 32'd4); end
      step(0, 0, 0, 0);
      checks++; if (PC_D !== sp + 32'd8) begin errors++; $display("FAIL stall_once: got %h want %h", PC_D, sp + 32'd8); end
   endtask

   task automatic test_redirect();
      hold_reset(); rst_n = 1'b1;
      repeat (4) step(0, 0, 0, 0);
      step(0, 0, 1, RPC + 32'h100);
      checks++; if (o_addr !== 12'h004) begin errors++; $display("FAIL redir_src: got %h want 004", o_addr); end
      step(0, 0, 0, 0);
      checks++; if (PC_D !== RPC + 32'h10 || instr_valid !== 1'b1 || o_addr !== 12'h040) begin
         errors++; $display("FAIL redir_delay_slot: got pc=%h v=%b addr=%h want pc=%h v=1 addr=040", PC_D, instr_valid, o_addr, RPC + 32'h10); end
      step(0, 0, 0, 0);
      checks++; if (PC_D !== RPC + 32'h100 || Instr !== mem_word(12'h040)) begin
         errors++; $display("FAIL redir_target: got pc=%h instr=%h want pc=%h", PC_D, Instr, RPC + 32'h100); end
   endtask

   task automatic test_redirect_stall();
      hold_reset(); rst_n = 1'b1;
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 1, RPC + 32'h200);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      checks++; if (o_addr !== 12'h080 || PC_D !== RPC + 32'h8) begin
         errors++; $display("FAIL pend_first_fetch: got addr=%h pc=%h want addr=080 pc=%h", o_addr, PC_D, RPC + 32'h8); end
      step(0, 0, 0, 0);
      checks++; if (o_addr !== 12'h081 || PC_D !== RPC + 32'h200) begin
         errors++; $display("FAIL pend_no_seq: got addr=%h pc=%h want addr=081 pc=%h", o_addr, PC_D, RPC + 32'h200); end
   endtask

   task automatic test_flush_stall();
      logic [11:0] last;
      hold_reset(); rst_n = 1'b1;
      repeat (3) step(0, 0, 0, 0);
      last = o_addr;
      step(1, 1, 0, 0);
      checks++; if (Instr !== 32'h0 || instr_valid !== 1'b0 || o_en !== 1'b0) begin
         errors++; $display("FAIL flush_bubble: got instr=%h v=%b en=%b want 0/0/0", Instr, instr_valid, o_en); end
      step(0, 0, 0, 0);
      checks++; if (o_addr !== last + 12'd1 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL flush_pc_kept: got addr=%h v=%b want addr=%h v=0", o_addr, instr_valid, last + 12'd1); end
      step(0, 0, 0, 0);
      checks++; if (PC_D !== RPC + 32'hC || instr_valid !== 1'b1) begin
         errors++; $display("FAIL flush_no_replay: got pc=%h v=%b want pc=%h v=1", PC_D, instr_valid, RPC + 32'hC); end
   endtask

   task automatic test_wrap();
      hold_reset(); rst_n = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      checks++; if (PC_D !== 32'hFFFF_FFFC || PC_plus4_D !== 32'h0 || o_addr !== 12'h000) begin
         errors++; $display("FAIL wrap: got pc=%h pc4=%h addr=%h want fffffffc/0/000", PC_D, PC_plus4_D, o_addr); end
      step(0, 0, 0, 0);
      checks++; if (PC_D !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 0", PC_D); end
   endtask

   task automatic test_misalign();
      hold_reset(); rst_n = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 1, RPC + 32'h102);
      step(0, 0, 0, 0);
      checks++; if (o_addr !== 12'h040) begin errors++; $display("FAIL align_addr: got %h want 040", o_addr); end
      step(0, 0, 0, 0);
      checks++; if (PC_D !== RPC + 32'h100) begin errors++; $display("FAIL align_pcd: got %h want %h", PC_D, RPC + 32'h100); end
`ifdef MIPS150_FETCH_ALIGN_CHK_EN
      checks++; if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b want 1", fetch_misalign); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (fetch_misalign !== 1'b0 || instr_valid !== 1'b0 || PC_D !== RPC) begin
         errors++; $display("FAIL misalign_reset: got flag=%b v=%b pc=%h want 0/0/%h", fetch_misalign, instr_valid, PC_D, RPC); end
      @(posedge clk); #1;
      rst_n = 1'b1;
`endif
   endtask

   task automatic test_reset_mid();
      hold_reset(); rst_n = 1'b1;
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 1, RPC + 32'h300);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (Instr !== 32'h0 || PC_D !== RPC || PC_plus4_D !== RPC + 32'd4 || instr_valid !== 1'b0 || imem_en !== 1'b0) begin
         errors++; $display("FAIL midrst_outputs: got instr=%h pc=%h pc4=%h v=%b en=%b", Instr, PC_D, PC_plus4_D, instr_valid, imem_en); end
      @(posedge clk); #1;
      model_reset();
      rst_n = 1'b1;
      step(1, 0, 0, 0);
      checks++; if (o_en !== 1'b1 || o_addr !== 12'h000) begin
         errors++; $display("FAIL midrst_boot: got en=%b addr=%h want en=1 addr=000", o_en, o_addr); end
      step(0, 0, 0, 0);
      checks++; if (o_addr !== 12'h001 || PC_D !== RPC || instr_valid !== 1'b1) begin
         errors++; $display("FAIL midrst_no_pending: got addr=%h pc=%h v=%b want 001/%h/1", o_addr, PC_D, instr_valid, RPC); end
   endtask

   task automatic test_random();
      logic s, f, rv;
      logic [31:0] t;
      hold_reset(); rst_n = 1'b1;
      for (int i = 0; i < 600; i++) begin
         s  = ($urandom_range(0, 99) < 30);
         f  = ($urandom_range(0, 99) < 10);
         rv = ($urandom_range(0, 99) < 12);
         t  = $urandom;
         step(s, f, rv, t);
         checks++; if (o_en !== e_en || (e_en && o_addr !== e_addr)) begin
            errors++; $display("FAIL rnd_fetch cyc%0d: got en=%b addr=%h want en=%b addr=%h", i, o_en, o_addr, e_en, e_addr); end
         checks++; if (Instr !== e_instr || instr_valid !== e_iv) begin
            errors++; $display("FAIL rnd_instr cyc%0d: got %h/%b want %h/%b", i, Instr, instr_valid, e_instr, e_iv); end
         checks++; if (PC_D !== e_pcd || PC_plus4_D !== e_pcd + 32'd4) begin
            errors++; $display("FAIL rnd_pc cyc%0d: got %h/%h want %h/%h", i, PC_D, PC_plus4_D, e_pcd, e_pcd + 32'd4); end
`ifdef MIPS150_FETCH_ALIGN_CHK_EN
         checks++; if (fetch_misalign !== m_mis) begin
            errors++; $display("FAIL rnd_misalign cyc%0d: got %b want %b", i, fetch_misalign, m_mis); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_flush_stall();
      test_wrap();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
